// File: rtl/encoder_83_req_if.sv
// ---------------------------------------------------------------------------
// encoder_83_req_if
//   Bundles the request lines, the code/valid/ready handshake and the status
//   outputs of the sequential 8-to-3 priority encoder.
//
//   Signals:
//     E              capture/issue enable, active-high
//     I0n..I7n       request lines, active-low, level
//     ready          consumer accepts the code when high together with valid
//     A0, A1, A2     encoded index, A2 = MSB (registered in the encoder)
//     valid          code on A2..A0 is valid (registered in the encoder)
//     GSn            group select, active-low
//     ovf            one-cycle pulse: new event on an already-pending line
//
//   Modports:
//     master  the requester/consumer side (drives E, I*n, ready)
//     slave   the encoder itself
// ---------------------------------------------------------------------------
interface encoder_83_req_if;
  logic E;
  logic I0n;
  logic I1n;
  logic I2n;
  logic I3n;
  logic I4n;
  logic I5n;
  logic I6n;
  logic I7n;
  logic ready;
  logic A0;
  logic A1;
  logic A2;
  logic valid;
  logic GSn;
  logic ovf;

  modport master (
    output E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n, ready,
    input  A0, A1, A2, valid, GSn, ovf
  );

  modport slave (
    input  E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n, ready,
    output A0, A1, A2, valid, GSn, ovf
  );
endinterface

// File: rtl/encoder_83_req.sv
// ---------------------------------------------------------------------------
// encoder_83_req
//   Sequential 8-to-3 priority encoder. Falling edges on eight active-low
//   request lines are captured into sticky pending bits; the highest-priority
//   pending index is offered as {A2,A1,A0} over a valid/ready handshake, and
//   acceptance clears the served pending bit.
//
//   Parameters:
//     HI_FIRST  1: index 7 has highest priority; 0: index 0 has highest.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   encoder_83_req_if.slave (E, I0n..I7n, ready in;
//           A0..A2, valid, GSn, ovf out)
// ---------------------------------------------------------------------------
module encoder_83_req #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  encoder_83_req_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  w_in_n;
  logic [7:0]  r_in_q;
  logic [7:0]  r_in_d;
  logic [7:0]  r_pending;
  logic [7:0]  w_pending_next;
  logic [7:0]  w_ev;
  logic [7:0]  w_clr;

  logic [2:0]  r_code;
  logic [2:0]  w_code_next;
  logic [2:0]  w_sel_code;
  logic        r_valid;
  logic        w_valid_next;
  logic        r_ovf;
  logic        w_ovf_next;
  logic        w_accept;
  logic        w_any_pending;

  assign w_in_n = {bus.I7n, bus.I6n, bus.I5n, bus.I4n,
                   bus.I3n, bus.I2n, bus.I1n, bus.I0n};

  // Two-stage input pipeline. Both stages reset to all-ones so a line held
  // low across reset release still shows exactly one falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_q <= 8'hFF;
      r_in_d <= 8'hFF;
    end else begin
      r_in_q <= w_in_n;
      r_in_d <= r_in_q;
    end
  end

  assign w_accept      = r_valid & bus.ready;
  assign w_any_pending = |r_pending;

  // Per-line event, clear and pending update. An event landing in the same
  // cycle as the clear of its own bit wins: it is a fresh request.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign w_ev[gi]           = r_in_d[gi] & ~r_in_q[gi] & bus.E;
      assign w_clr[gi]          = w_accept & (r_code == 3'(gi));
      assign w_pending_next[gi] = (r_pending[gi] & ~w_clr[gi]) | w_ev[gi];
    end
  endgenerate

  // Overflow only counts events on bits that survive this cycle, so an event
  // coinciding with its own acceptance is not an overflow.
  assign w_ovf_next = |(w_ev & r_pending & ~w_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_ovf     <= w_ovf_next;
    end
  end

  // Priority pick from the registered pending bits only; the later loop
  // iteration overrides earlier ones, so loop direction sets the priority.
  always_comb begin
    w_sel_code = 3'd0;
    if (HI_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (r_pending[i]) begin
          w_sel_code = i[2:0];
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pending[i]) begin
          w_sel_code = i[2:0];
        end
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
    end
  end

  // IDLE loads a code only when enabled; HOLD completes regardless of E so an
  // in-flight transfer is never stranded. Returning through IDLE after every
  // transfer gives the one-idle-cycle spacing between codes.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = r_valid;
    case (r_state)
      ST_IDLE: begin
        w_valid_next = 1'b0;
        if (bus.E && w_any_pending) begin
          w_code_next  = w_sel_code;
          w_valid_next = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.ready) begin
          w_valid_next = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.A0    = r_code[0];
  assign bus.A1    = r_code[1];
  assign bus.A2    = r_code[2];
  assign bus.valid = r_valid;
  assign bus.ovf   = r_ovf;
  assign bus.GSn   = ~(bus.E & w_any_pending);

endmodule

// File: tb/tb_encoder_83_req.sv
// ---------------------------------------------------------------------------
// tb_encoder_83_req
//   Drives two encoders (HI_FIRST=1 and HI_FIRST=0) with identical stimulus.
//   A per-cycle vector table covers single-request latency and priority order
//   for both orderings; hand-written sequences cover hold/backpressure,
//   overflow, enable gating and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_encoder_83_req;

  logic       clk = 1'b0;
  logic       rst;
  logic       e_r;
  logic       rdy_r;
  logic [7:0] in_r;

  always #5 clk = ~clk;

  encoder_83_req_if bus_hi ();
  encoder_83_req_if bus_lo ();

  assign bus_hi.E     = e_r;
  assign bus_hi.ready = rdy_r;
  assign bus_hi.I0n   = in_r[0];
  assign bus_hi.I1n   = in_r[1];
  assign bus_hi.I2n   = in_r[2];
  assign bus_hi.I3n   = in_r[3];
  assign bus_hi.I4n   = in_r[4];
  assign bus_hi.I5n   = in_r[5];
  assign bus_hi.I6n   = in_r[6];
  assign bus_hi.I7n   = in_r[7];

  assign bus_lo.E     = e_r;
  assign bus_lo.ready = rdy_r;
  assign bus_lo.I0n   = in_r[0];
  assign bus_lo.I1n   = in_r[1];
  assign bus_lo.I2n   = in_r[2];
  assign bus_lo.I3n   = in_r[3];
  assign bus_lo.I4n   = in_r[4];
  assign bus_lo.I5n   = in_r[5];
  assign bus_lo.I6n   = in_r[6];
  assign bus_lo.I7n   = in_r[7];

  encoder_83_req #(.HI_FIRST(1'b1)) u_dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));
  encoder_83_req #(.HI_FIRST(1'b0)) u_dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));

  logic [2:0] code_hi;
  logic [2:0] code_lo;
  assign code_hi = {bus_hi.A2, bus_hi.A1, bus_hi.A0};
  assign code_lo = {bus_lo.A2, bus_lo.A1, bus_lo.A0};

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] in_n;
    logic       e;
    logic       rdy;
    logic       v;
    logic [2:0] c_hi;
    logic [2:0] c_lo;
    logic       gsn;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Compare one instance's outputs; code is compared only while valid.
  task automatic chk_out(input string tag, input bit lo, input logic ev,
                         input logic [2:0] ec, input logic eg, input logic eo);
    logic       av;
    logic [2:0] ac;
    logic       ag;
    logic       ao;
    av = lo ? bus_lo.valid : bus_hi.valid;
    ac = lo ? code_lo      : code_hi;
    ag = lo ? bus_lo.GSn   : bus_hi.GSn;
    ao = lo ? bus_lo.ovf   : bus_hi.ovf;
    chk({tag, ".valid"}, int'(av), int'(ev));
    if (ev) chk({tag, ".code"}, int'(ac), int'(ec));
    chk({tag, ".GSn"}, int'(ag), int'(eg));
    chk({tag, ".ovf"}, int'(ao), int'(eo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int issues_of_1;

  initial begin
    rst   = 1'b1;
    e_r   = 1'b1;
    rdy_r = 1'b1;
    in_r  = 8'hFF;
    repeat (2) tick();
    chk_out("reset_hi", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_out("reset_lo", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("reset_code_hi", int'(code_hi), 0);
    chk("reset_code_lo", int'(code_lo), 0);
    rst = 1'b0;
    tick();

    // Single request on line 5: valid for exactly one cycle at edge k+2.
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hDF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hDF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{8'hDF, 1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    // Lines 2, 3, 6 together: 6,3,2 (HI_FIRST=1) vs 2,3,6 (HI_FIRST=0).
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b1, 3'd6, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b1, 3'd2, 3'd6, 1'b0, 1'b0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      in_r  = vecs[i].in_n;
      e_r   = vecs[i].e;
      rdy_r = vecs[i].rdy;
      tick();
      chk_out($sformatf("vec%0d_hi", i), 1'b0, vecs[i].v, vecs[i].c_hi, vecs[i].gsn, vecs[i].ovf);
      chk_out($sformatf("vec%0d_lo", i), 1'b1, vecs[i].v, vecs[i].c_lo, vecs[i].gsn, vecs[i].ovf);
    end
    $display("table vectors done: %0d/%0d", n_pass, n_total);

    // Backpressure: code 4 holds 5 cycles; line 7 arriving meanwhile waits.
    rdy_r = 1'b0;
    in_r  = 8'hEF;
    repeat (2) tick();
    chk("hold_pre_valid", int'(bus_hi.valid), 0);
    tick();
    chk_out("hold_load", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) in_r = 8'h6F;
      tick();
      chk_out($sformatf("hold_c%0d", i), 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    end
    rdy_r = 1'b1;
    tick();
    chk("hold_accept_valid", int'(bus_hi.valid), 0);
    tick();
    chk_out("hold_next7", 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    tick();
    chk_out("hold_done", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    in_r = 8'hFF;
    repeat (2) tick();
    $display("hold sequence done: %0d/%0d", n_pass, n_total);

    // Overflow: second edge on line 1 while pending and not served.
    rdy_r = 1'b0;
    in_r  = 8'hED;
    repeat (3) tick();
    chk_out("ovf_load4", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    in_r = 8'hEF;
    tick();
    in_r = 8'hED;
    tick();
    chk("ovf_before", int'(bus_hi.ovf), 0);
    tick();
    chk_out("ovf_pulse", 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    tick();
    chk("ovf_after", int'(bus_hi.ovf), 0);
    rdy_r = 1'b1;
    issues_of_1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_hi.valid && code_hi == 3'd1) issues_of_1++;
    end
    chk("ovf_single_issue", issues_of_1, 1);
    chk("ovf_gsn_idle", int'(bus_hi.GSn), 1);
    in_r = 8'hFF;
    repeat (2) tick();
    $display("ovf sequence done: %0d/%0d", n_pass, n_total);

    // Edge on line 1 coinciding with acceptance of code 1: re-issue, no ovf.
    rdy_r = 1'b0;
    in_r  = 8'hFD;
    repeat (3) tick();
    chk_out("coin_load1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    in_r = 8'hFF;
    repeat (2) tick();
    in_r = 8'hFD;
    tick();
    chk("coin_pre_ovf", int'(bus_hi.ovf), 0);
    rdy_r = 1'b1;
    tick();
    chk_out("coin_accept", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("coin_reissue", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    chk_out("coin_done", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    in_r = 8'hFF;
    repeat (2) tick();
    $display("coincide sequence done: %0d/%0d", n_pass, n_total);

    // E=0: toggling I0n captures nothing.
    e_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_r = (i % 2 == 0) ? 8'hFE : 8'hFF;
      tick();
      chk_out($sformatf("en0_t%0d", i), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    tick();
    e_r = 1'b1;
    repeat (2) tick();
    chk_out("en0_reenable", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

    // E falls while code 5 is in flight: it completes, line 2 waits for E.
    rdy_r = 1'b0;
    in_r  = 8'hDB;
    repeat (3) tick();
    chk_out("en_load5", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    e_r = 1'b0;
    #1;
    chk("en_gsn_off", int'(bus_hi.GSn), 1);
    tick();
    chk_out("en_hold5", 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    rdy_r = 1'b1;
    tick();
    chk("en_accept5", int'(bus_hi.valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("en_idle%0d", i), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    e_r = 1'b1;
    #1;
    chk("en_gsn_retained", int'(bus_hi.GSn), 0);
    tick();
    chk_out("en_issue2", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("en_done", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    in_r = 8'hFF;
    repeat (2) tick();
    $display("enable sequence done: %0d/%0d", n_pass, n_total);

    // Asynchronous reset mid-transfer with three lines pending.
    rdy_r = 1'b0;
    in_r  = 8'hB5;
    repeat (3) tick();
    chk_out("rst_load6", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("rst_async_code", int'(code_hi), 0);
    in_r = 8'hFF;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("rst_post%0d", i), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    $display("reset sequence done: %0d/%0d", n_pass, n_total);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
